// File: rtl/cache_refill_controller.sv
// cache_refill_controller: single-word cache refill / store-through controller.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rd_req_i, wr_req_i            CPU load / store request (store wins when both)
//   addr_i, wdata_i               CPU address / store data
//   hit_i, cache_data_i           cache lookup result for addr_i
//   mem_req_o, mem_we_o           memory request / write enable
//   mem_addr_o, mem_wdata_o       word-aligned memory address / write data
//   mem_ack_i, mem_rdata_i        memory completion / read data
//   fill_o, fill_addr_o/data_o    cache write strobe, address, data
//   rdata_o, stall_o, done_o      load result, CPU stall, completion
//   err_o                         memory timeout
//   miss_count_o                  saturating read-miss count (REFILL_MISS_COUNTER_EN only)
// Optional feature macro: REFILL_MISS_COUNTER_EN
module cache_refill_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req_i,
    input  logic                  wr_req_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  hit_i,
    input  logic [DATA_WIDTH-1:0] cache_data_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  fill_o,
    output logic [DATA_WIDTH-1:0] fill_addr_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    output logic                  done_o,
`ifdef REFILL_MISS_COUNTER_EN
    output logic [15:0]           miss_count_o,
`endif
    output logic                  err_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, READ_MEM, WRITE_MEM, FILL} state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_addr, r_data, w_rdata;
    logic                  r_hit;
    logic                  w_wait, w_timeout, w_stall, w_done, w_err, w_rd_miss, w_wr_acc;

    assign w_wait    = (r_state == READ_MEM) || (r_state == WRITE_MEM);
    // An ack in the timeout cycle wins, so the timeout is qualified by !mem_ack_i.
    assign w_timeout = w_wait && !mem_ack_i && (r_cnt == CW'(TIMEOUT_CYCLES));

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_rdata   = '0;
        w_rd_miss = 1'b0;
        w_wr_acc  = 1'b0;
        case (r_state)
            IDLE: begin
                w_wr_acc  = wr_req_i;
                w_rd_miss = !wr_req_i && rd_req_i && !hit_i;
                w_stall   = wr_req_i || w_rd_miss;
                w_done    = !wr_req_i && rd_req_i && hit_i;
                w_rdata   = w_done ? cache_data_i : '0;
                w_next    = wr_req_i ? WRITE_MEM : (w_rd_miss ? READ_MEM : IDLE);
            end
            READ_MEM, WRITE_MEM: begin
                w_stall = 1'b1;
                w_err   = w_timeout;
                // A store miss completes directly on its ack; no cache update needed.
                w_done  = w_timeout || (mem_ack_i && r_state == WRITE_MEM && !r_hit);
                w_next  = w_timeout ? IDLE :
                          !mem_ack_i ? r_state :
                          (r_state == READ_MEM || r_hit) ? FILL : IDLE;
            end
            default: begin
                w_done  = 1'b1;
                w_rdata = r_data;
                w_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_wait && w_next == r_state) ? r_cnt + CW'(1) : '0;
            if (w_wr_acc || w_rd_miss)
                r_addr <= addr_i & ~DATA_WIDTH'(3);
            if (w_wr_acc) begin
                r_data <= wdata_i;
                r_hit  <= hit_i;
            end
            if (r_state == READ_MEM && mem_ack_i)
                r_data <= mem_rdata_i;
        end
    end

`ifdef REFILL_MISS_COUNTER_EN
    logic [15:0] r_miss;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_miss <= '0;
        else if (w_rd_miss && r_miss != 16'hFFFF)
            r_miss <= r_miss + 16'd1;
    end
    assign miss_count_o = r_miss;
`endif

    // Combinational IDLE paths are masked so every output reads zero while rst is high.
    assign mem_req_o   = !rst && w_wait;
    assign mem_we_o    = !rst && r_state == WRITE_MEM;
    assign mem_addr_o  = mem_req_o ? r_addr : '0;
    assign mem_wdata_o = mem_we_o ? r_data : '0;
    assign fill_o      = !rst && r_state == FILL;
    assign fill_addr_o = fill_o ? r_addr : '0;
    assign fill_data_o = fill_o ? r_data : '0;
    assign rdata_o     = rst ? '0 : w_rdata;
    assign stall_o     = !rst && w_stall;
    assign done_o      = !rst && w_done;
    assign err_o       = !rst && w_err;
endmodule

// File: tb/tb_cache_refill_controller.sv
// tb_cache_refill_controller: scoreboard bench for cache_refill_controller.
module tb_cache_refill_controller;
    logic        clk = 1'b0, rst = 1'b1;
    logic        rd_req_i = 0, wr_req_i = 0, hit_i = 0, mem_ack_i = 0;
    logic [31:0] addr_i = 0, wdata_i = 0, cache_data_i = 0, mem_rdata_i = 0;
    logic        mem_req_o, mem_we_o, fill_o, stall_o, done_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, fill_addr_o, fill_data_o, rdata_o;
`ifdef REFILL_MISS_COUNTER_EN
    logic [15:0] miss_count_o;
`endif

    cache_refill_controller #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .rd_req_i(rd_req_i), .wr_req_i(wr_req_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .hit_i(hit_i), .cache_data_i(cache_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .fill_o(fill_o), .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
        .rdata_o(rdata_o), .stall_o(stall_o), .done_o(done_o),
`ifdef REFILL_MISS_COUNTER_EN
        .miss_count_o(miss_count_o),
`endif
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, stall_cnt = 0;
    logic prev_done = 1'b0;
    logic [63:0] exp_fill[$];
    logic [32:0] exp_done[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: pops expected fill/done records when the DUT produces them.
    always @(negedge clk) begin
        if (rst) prev_done = 1'b0;
        else begin
            if (stall_o) stall_cnt++;
            if (fill_o) begin
                if (exp_fill.size() == 0) chk("fill_unexpected", 64'(fill_o), 0);
                else chk("fill", {fill_addr_o, fill_data_o}, exp_fill.pop_front());
            end
            if (done_o) begin
                chk("done_consec", 64'(prev_done), 0);
                if (exp_done.size() == 0) chk("done_unexpected", 64'(done_o), 0);
                else chk("done", 64'({err_o, rdata_o}), 64'(exp_done.pop_front()));
            end
            prev_done = done_o;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_read_miss(input logic [31:0] a);
        step();
        rd_req_i = 1; hit_i = 0; addr_i = a; stall_cnt = 0;
        step();
        rd_req_i = 0;
    endtask

    initial begin
        // Reset: outputs zero even with a live hit request on the inputs.
        rd_req_i = 1; hit_i = 1; cache_data_i = 32'hFFFF_FFFF;
        #12;
        chk("rst_done", 64'(done_o), 0);
        chk("rst_rdata", 64'(rdata_o), 0);
        chk("rst_stall", 64'(stall_o), 0);
        chk("rst_memreq", 64'(mem_req_o), 0);
        rd_req_i = 0; hit_i = 0;
        step(); rst = 0;

        // Read hit
        step();
        rd_req_i = 1; hit_i = 1; cache_data_i = 32'hDEADBEEF; stall_cnt = 0;
        exp_done.push_back({1'b0, 32'hDEADBEEF});
        #1 chk("hit_rdata_comb", 64'(rdata_o), 64'hDEADBEEF);
        @(negedge clk) chk("hit_memreq", 64'(mem_req_o), 0);
        step();
        rd_req_i = 0; hit_i = 0;
        @(negedge clk) chk("hit_memreq2", 64'(mem_req_o), 0);
        chk("hit_stall", 64'(stall_cnt), 0);

        // Read miss: ack in the third wait cycle
        exp_fill.push_back({32'h0000_1004, 32'h12345678});
        exp_done.push_back({1'b0, 32'h12345678});
        start_read_miss(32'h0000_1007);
        @(negedge clk) begin
            chk("rm_addr", 64'(mem_addr_o), 64'h1004);
            chk("rm_we", 64'(mem_we_o), 0);
            chk("rm_req", 64'(mem_req_o), 1);
        end
        step(); step();
        mem_ack_i = 1; mem_rdata_i = 32'h12345678;
        step();
        mem_ack_i = 0;
        @(negedge clk) chk("rm_fill_stall", 64'(stall_o), 0);
        step();
        chk("rm_stall_cycles", 64'(stall_cnt), 4);

        // Store hit
        step();
        wr_req_i = 1; hit_i = 1; addr_i = 32'h2002; wdata_i = 32'hA5A5A5A5;
        exp_fill.push_back({32'h0000_2000, 32'hA5A5A5A5});
        exp_done.push_back({1'b0, 32'hA5A5A5A5});
        step();
        wr_req_i = 0; hit_i = 0; wdata_i = 0;
        @(negedge clk) begin
            chk("sh_we", 64'(mem_we_o), 1);
            chk("sh_wdata", 64'(mem_wdata_o), 64'hA5A5A5A5);
        end
        step();
        mem_ack_i = 1;
        @(negedge clk) chk("sh_we_ack", 64'(mem_we_o), 1);
        step();
        mem_ack_i = 0;
        step();

        // Store miss with a simultaneous read: the store wins, no fill
        step();
        wr_req_i = 1; rd_req_i = 1; hit_i = 0; addr_i = 32'h3003; wdata_i = 32'h5A5A5A5A;
        exp_done.push_back({1'b0, 32'h0});
        step();
        wr_req_i = 0; rd_req_i = 0;
        @(negedge clk) begin
            chk("sm_we", 64'(mem_we_o), 1);
            chk("sm_addr", 64'(mem_addr_o), 64'h3000);
        end
        mem_ack_i = 1;
        step();
        mem_ack_i = 0;
        @(negedge clk) chk("sm_idle_req", 64'(mem_req_o), 0);

        // Ack in the timeout cycle takes precedence
        exp_fill.push_back({32'h0000_5000, 32'hCAFEF00D});
        exp_done.push_back({1'b0, 32'hCAFEF00D});
        start_read_miss(32'h5001);
        step(); step(); step(); step();
        mem_ack_i = 1; mem_rdata_i = 32'hCAFEF00D;
        @(negedge clk) chk("ack_at_to_err", 64'(err_o), 0);
        step();
        mem_ack_i = 0;
        step();

        // Timeout: error exactly at wait count 4
        exp_done.push_back({1'b1, 32'h0});
        start_read_miss(32'h6000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) chk($sformatf("to_err_%0d", i), 64'(err_o), 64'(i == 4));
            step();
        end
        @(negedge clk) chk("to_idle_req", 64'(mem_req_o), 0);
`ifdef REFILL_MISS_COUNTER_EN
        chk("miss_count", 64'(miss_count_o), 3);
`endif

        // Reset mid-transaction, then a stale ack
        start_read_miss(32'h7000);
        #2 rst = 1;
        #1 chk("rst_async_req", 64'(mem_req_o), 0);
        chk("rst_async_stall", 64'(stall_o), 0);
        step();
        rst = 0; mem_ack_i = 1; mem_rdata_i = 32'hBAD0BAD0;
        step(); step();
        mem_ack_i = 0;
        @(negedge clk) chk("rst_after_req", 64'(mem_req_o), 0);
        step();

        chk("fill_q_empty", 64'(exp_fill.size()), 0);
        chk("done_q_empty", 64'(exp_done.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
